// File: rtl/accu_cpu_core_if.sv
// Memory port of the accumulator core.
//   master (core): mem_en, mem_we, mem_addr, mem_wdata out; mem_rdata in
//   slave  (RAM) : the mirror image
// A read presented on mem_en/mem_addr returns data on mem_rdata in the
// following cycle; a write is taken when mem_en && mem_we.
interface accu_cpu_core_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/accu_cpu_core.sv
// Accumulator CPU core: control and datapath in one block, single-port RAM.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   ce               clock enable (all state holds when low; rst still acts)
//   boot             boot loader owns memory; core held, memory port idle
//   run              level: free-run / halt at next instruction boundary
//   step             pulse: execute one instruction while halted
//   bp_en, bp_addr   PC breakpoint
//   mem              memory port (accu_cpu_core_if.master)
//   pc, accu, carry  architectural state
//   halted           core is in HALT (or held by boot)
// ISA (opcode = top two bits, operand = low ADDR_W bits):
//   00 NOR  ACC = ~(ACC | M)      01 ADD  {carry,ACC} = ACC + M
//   10 STA  M = ACC               11 JCC  carry ? clear carry : jump
module accu_cpu_core #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned RESET_PC     = 0,
  parameter bit          RUN_AT_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              boot,
  input  logic              run,
  input  logic              step,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  accu_cpu_core_if.master   mem,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] accu,
  output logic              carry,
  output logic              halted
);

  localparam int unsigned OP_W = 2;
  localparam logic [OP_W-1:0] OP_NOR = 2'b00;
  localparam logic [OP_W-1:0] OP_ADD = 2'b01;
  localparam logic [OP_W-1:0] OP_STA = 2'b10;
  localparam logic [OP_W-1:0] OP_JCC = 2'b11;

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_BOOT
  } state_t;

  localparam state_t RESET_STATE = RUN_AT_RESET ? S_FETCH : S_HALT;

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic              run_q;   // previous run level, for rising-edge detection
  logic              single;  // current instruction was started by step

  logic [ADDR_W-1:0] pc_inc;
  logic [OP_W-1:0]   rd_op;
  logic [ADDR_W-1:0] rd_operand;
  logic [DATA_W:0]   sum;
  logic              go_pc, go_inc, go_jmp;
  logic              unused_ir_bits;

  assign pc_inc     = pc + ADDR_W'(1);
  assign rd_op      = mem.mem_rdata[DATA_W-1 -: OP_W];
  assign rd_operand = mem.mem_rdata[ADDR_W-1:0];
  assign sum        = {1'b0, accu} + {1'b0, mem.mem_rdata};
  assign unused_ir_bits = ^ir[DATA_W-OP_W-1:0];

  // Boundary decision for each possible next PC: continue only when free
  // running, not single-stepping and not landing on the breakpoint.
  assign go_pc  = run && !single && !(bp_en && (pc == bp_addr));
  assign go_inc = run && !single && !(bp_en && (pc_inc == bp_addr));
  assign go_jmp = run && !single && !(bp_en && (rd_operand == bp_addr));

  // Sequencer and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RESET_STATE;
      halted        <= !RUN_AT_RESET;
      pc            <= ADDR_W'(RESET_PC);
      accu          <= '0;
      carry         <= 1'b0;
      ir            <= '0;
      run_q         <= 1'b0;
      single        <= 1'b0;
      mem.mem_en    <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else if (boot) begin
      // Abort anything in flight; clearing run_q makes release behave like reset.
      state      <= S_BOOT;
      halted     <= 1'b1;
      run_q      <= 1'b0;
      single     <= 1'b0;
      mem.mem_en <= 1'b0;
      mem.mem_we <= 1'b0;
    end else if (ce) begin
      run_q      <= run;
      mem.mem_en <= 1'b0;
      mem.mem_we <= 1'b0;
      case (state)
        S_BOOT: begin
          pc     <= ADDR_W'(RESET_PC);
          accu   <= '0;
          carry  <= 1'b0;
          state  <= RESET_STATE;
          halted <= !RUN_AT_RESET;
        end
        S_HALT: begin
          // Leaving HALT skips the breakpoint check so a resume cannot deadlock.
          if (run && !run_q) begin
            state  <= S_FETCH;
            halted <= 1'b0;
            single <= 1'b0;
          end else if (step) begin
            state  <= S_FETCH;
            halted <= 1'b0;
            single <= !run;
          end
        end
        S_FETCH: begin
          mem.mem_en   <= 1'b1;
          mem.mem_addr <= pc;
          state        <= S_DECODE;
        end
        S_DECODE: begin
          ir <= mem.mem_rdata;
          pc <= pc_inc;
          case (rd_op)
            OP_NOR, OP_ADD: begin
              mem.mem_en   <= 1'b1;
              mem.mem_addr <= rd_operand;
              state        <= S_EXEC;
            end
            OP_STA: begin
              mem.mem_en    <= 1'b1;
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= rd_operand;
              mem.mem_wdata <= accu;
              state         <= go_inc ? S_FETCH : S_HALT;
              halted        <= !go_inc;
            end
            default: begin
              if (!carry) begin
                pc     <= rd_operand;
                state  <= go_jmp ? S_FETCH : S_HALT;
                halted <= !go_jmp;
              end else begin
                carry  <= 1'b0;
                state  <= go_inc ? S_FETCH : S_HALT;
                halted <= !go_inc;
              end
            end
          endcase
        end
        S_EXEC: begin
          if (ir[DATA_W-1 -: OP_W] == OP_ADD) begin
            {carry, accu} <= sum;
          end else begin
            accu <= ~(accu | mem.mem_rdata);
          end
          state  <= go_pc ? S_FETCH : S_HALT;
          halted <= !go_pc;
        end
        default: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule
